// File: rtl/free_list_manager_pkg.sv
// Shared sizing constants for the physical-register free list and its
// branch checkpoint store.
package free_list_manager_pkg;

   localparam int PHYS_REG_NUM           = 64;
   localparam int REG_NUM                = 32;
   localparam int CKPT_NUM               = 16;
   localparam int PHYS_REG_NUM_INDEX     = $clog2(PHYS_REG_NUM);
   localparam int ACTIVE_LIST_SIZE_INDEX = $clog2(CKPT_NUM);
   // Extra MSB is the wrap bit that tells a full list from an empty one.
   localparam int PTR_W                  = PHYS_REG_NUM_INDEX + 1;

endpackage

// File: rtl/free_list_manager_ckpt_store.sv
// Per-branch snapshots of the free-list head pointer: one write port,
// one combinational read port.
module free_list_ckpt_store #(
   parameter int CKPT_NUM = free_list_manager_pkg::CKPT_NUM,
   parameter int PTR_W    = free_list_manager_pkg::PTR_W,
   parameter int CID_W    = $clog2(CKPT_NUM)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [CID_W-1:0] wr_id,
   input  logic [PTR_W-1:0] wr_ptr,
   input  logic [CID_W-1:0] rd_id,
   output logic [PTR_W-1:0] rd_ptr
);

   logic [PTR_W-1:0] ckpt_q [CKPT_NUM];
   logic [PTR_W-1:0] ckpt_d [CKPT_NUM];

   generate
      for (genvar gi = 0; gi < CKPT_NUM; gi++) begin : g_entry
         always_comb begin
            ckpt_d[gi] = ckpt_q[gi];
            if (wr_en && (wr_id == CID_W'(gi))) begin
               ckpt_d[gi] = wr_ptr;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ckpt_q[gi] <= '0;
            end else begin
               ckpt_q[gi] <= ckpt_d[gi];
            end
         end
      end
   endgenerate

   assign rd_ptr = ckpt_q[rd_id];

endmodule

// File: rtl/free_list_manager.sv
// Circular free list of physical registers with checkpointed head for
// branch-mispredict recovery and a sticky overflow flag.
module free_list_manager #(
   parameter int PHYS_REG_NUM = free_list_manager_pkg::PHYS_REG_NUM,
   parameter int REG_NUM      = free_list_manager_pkg::REG_NUM,
   parameter int CKPT_NUM     = free_list_manager_pkg::CKPT_NUM,
   parameter int IDX_W        = $clog2(PHYS_REG_NUM),
   parameter int PTR_W        = IDX_W + 1,
   parameter int CID_W        = $clog2(CKPT_NUM)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc_req,
   output logic             alloc_valid,
   output logic [IDX_W-1:0] alloc_preg,
   input  logic             reclaim_valid,
   input  logic [IDX_W-1:0] reclaim_preg,
   input  logic             ckpt_save,
   input  logic [CID_W-1:0] ckpt_id,
   input  logic             recover,
   input  logic [CID_W-1:0] recover_id,
   output logic [PTR_W-1:0] free_count,
   output logic             empty,
   output logic             overflow_err
);

   logic [IDX_W-1:0] list_q [PHYS_REG_NUM];
   logic [IDX_W-1:0] list_d [PHYS_REG_NUM];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [PTR_W-1:0] ckpt_rd_ptr;
   logic             full;

   assign empty        = (count_q == '0);
   assign full         = (count_q == PTR_W'(PHYS_REG_NUM));
   assign free_count   = count_q;
   assign overflow_err = ovf_q;
   // No bypass: a reclaim this cycle cannot satisfy a request on an empty list.
   assign alloc_valid  = alloc_req & ~empty & ~recover;
   assign alloc_preg   = list_q[head_q[IDX_W-1:0]];

   always_comb begin
      list_d = list_q;
      head_d = head_q;
      tail_d = tail_q;
      ovf_d  = ovf_q;
      if (recover) begin
         head_d = ckpt_rd_ptr;
      end else if (alloc_valid) begin
         head_d = head_q + PTR_W'(1);
      end
      if (reclaim_valid) begin
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            list_d[tail_q[IDX_W-1:0]] = reclaim_preg;
            tail_d = tail_q + PTR_W'(1);
         end
      end
      count_d = tail_d - head_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PHYS_REG_NUM; i++) begin
            list_q[i] <= (i < PHYS_REG_NUM - REG_NUM) ? IDX_W'(REG_NUM + i) : '0;
         end
         head_q  <= '0;
         tail_q  <= PTR_W'(PHYS_REG_NUM - REG_NUM);
         count_q <= PTR_W'(PHYS_REG_NUM - REG_NUM);
         ovf_q   <= 1'b0;
      end else begin
         list_q  <= list_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Snapshot includes this cycle's grant; a recover in the same cycle wins.
   free_list_ckpt_store #(
      .CKPT_NUM (CKPT_NUM),
      .PTR_W    (PTR_W),
      .CID_W    (CID_W)
   ) u_ckpt (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (ckpt_save & ~recover),
      .wr_id  (ckpt_id),
      .wr_ptr (head_d),
      .rd_id  (recover_id),
      .rd_ptr (ckpt_rd_ptr)
   );

endmodule

// File: tb/tb_free_list_manager.sv
// Self-checking bench for free_list_manager: hand-computed vector table,
// hand-written corner sequences and a scoreboarded random phase.
module tb_free_list_manager;

   localparam int P = 64;
   localparam int R = 32;
   localparam int C = 16;
   localparam int M = 2 * P;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       alloc_req = 1'b0;
   logic       alloc_valid;
   logic [5:0] alloc_preg;
   logic       reclaim_valid = 1'b0;
   logic [5:0] reclaim_preg = '0;
   logic       ckpt_save = 1'b0;
   logic [3:0] ckpt_id = '0;
   logic       recover = 1'b0;
   logic [3:0] recover_id = '0;
   logic [6:0] free_count;
   logic       empty;
   logic       overflow_err;

   always #5 clk = ~clk;

   free_list_manager #(.PHYS_REG_NUM(P), .REG_NUM(R), .CKPT_NUM(C)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alloc_req     (alloc_req),
      .alloc_valid   (alloc_valid),
      .alloc_preg    (alloc_preg),
      .reclaim_valid (reclaim_valid),
      .reclaim_preg  (reclaim_preg),
      .ckpt_save     (ckpt_save),
      .ckpt_id       (ckpt_id),
      .recover       (recover),
      .recover_id    (recover_id),
      .free_count    (free_count),
      .empty         (empty),
      .overflow_err  (overflow_err)
   );

   typedef struct {
      bit valid;
      int preg;
      int count;
      bit emp;
      bit ovf;
   } exp_t;

   typedef struct {
      bit a;  bit rv; int rp;
      bit sv; int sid;
      bit rc; int rid;
      bit ev; int ep; int ec;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[12];

   int total = 0;
   int bad   = 0;

   int m_list[P];
   int m_ckpt[C];
   int m_head, m_tail;
   bit m_ovf;

   bit s_valid;
   int s_preg, s_count;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic int m_count();
      return (m_tail - m_head + M) % M;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < P; i++) m_list[i] = (i < P - R) ? R + i : 0;
      for (int i = 0; i < C; i++) m_ckpt[i] = 0;
      m_head = 0;
      m_tail = P - R;
      m_ovf  = 1'b0;
      sb.delete();
   endtask

   task automatic idle_inputs();
      alloc_req = 1'b0; reclaim_valid = 1'b0; reclaim_preg = '0;
      ckpt_save = 1'b0; ckpt_id = '0; recover = 1'b0; recover_id = '0;
   endtask

   // Enters and leaves at a falling clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_count", int'(free_count), P - R);
      chk("rst_empty", int'(empty), 0);
      chk("rst_ovf", int'(overflow_err), 0);
      chk("rst_valid", int'(alloc_valid), 0);
      @(negedge clk);
   endtask

   task automatic step(input bit a, input bit rv, input int rp, input bit sv,
                       input int sid, input bit rc, input int rid);
      exp_t e, got;
      int   cnt, hn;
      bit   g;
      cnt = m_count();
      g   = a && (cnt != 0) && !rc;
      e.valid = g;
      e.preg  = m_list[m_head % P];
      hn = rc ? m_ckpt[rid] : (m_head + (g ? 1 : 0)) % M;
      if (rv) begin
         if (cnt == P) m_ovf = 1'b1;
         else begin
            m_list[m_tail % P] = rp;
            m_tail = (m_tail + 1) % M;
         end
      end
      if (sv && !rc) m_ckpt[sid] = hn;
      m_head  = hn;
      e.count = m_count();
      e.emp   = (e.count == 0);
      e.ovf   = m_ovf;
      sb.push_back(e);

      alloc_req = a; reclaim_valid = rv; reclaim_preg = 6'(rp);
      ckpt_save = sv; ckpt_id = 4'(sid); recover = rc; recover_id = 4'(rid);
      #1;
      s_valid = alloc_valid;
      s_preg  = int'(alloc_preg);
      chk("sb_valid", int'(alloc_valid), int'(sb[0].valid));
      if (sb[0].valid) chk("sb_preg", int'(alloc_preg), sb[0].preg);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      s_count = int'(free_count);
      chk("sb_count", int'(free_count), got.count);
      chk("sb_empty", int'(empty), int'(got.emp));
      chk("sb_ovf", int'(overflow_err), int'(got.ovf));
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      //         a  rv rp sv sid rc rid  ev ep  ec
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,  1, 32, 31};
      tbl[1]  = '{1, 0, 0, 0, 0, 0, 0,  1, 33, 30};
      tbl[2]  = '{1, 0, 0, 0, 0, 0, 0,  1, 34, 29};
      tbl[3]  = '{1, 0, 0, 1, 2, 0, 0,  1, 35, 28};
      tbl[4]  = '{1, 0, 0, 0, 0, 0, 0,  1, 36, 27};
      tbl[5]  = '{1, 0, 0, 0, 0, 0, 0,  1, 37, 26};
      tbl[6]  = '{1, 0, 0, 0, 0, 0, 0,  1, 38, 25};
      tbl[7]  = '{1, 0, 0, 0, 0, 0, 0,  1, 39, 24};
      tbl[8]  = '{0, 0, 0, 0, 0, 1, 2,  0,  0, 28};
      tbl[9]  = '{1, 0, 0, 0, 0, 0, 0,  1, 36, 27};
      tbl[10] = '{1, 1, 40, 1, 5, 1, 2, 0,  0, 29};
      tbl[11] = '{1, 0, 0, 0, 0, 0, 0,  1, 36, 28};

      @(negedge clk);
      do_reset();

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].a, tbl[i].rv, tbl[i].rp, tbl[i].sv, tbl[i].sid,
              tbl[i].rc, tbl[i].rid);
         chk($sformatf("tbl%0d_valid", i), int'(s_valid), int'(tbl[i].ev));
         if (tbl[i].ev) chk($sformatf("tbl%0d_preg", i), s_preg, tbl[i].ep);
         chk($sformatf("tbl%0d_count", i), s_count, tbl[i].ec);
      end

      // Asynchronous reset in the middle of a cycle with a request pending.
      alloc_req = 1'b1;
      reclaim_valid = 1'b1;
      reclaim_preg = 6'd9;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_count", int'(free_count), P - R);
      chk("midrst_preg", int'(alloc_preg), R);
      do_reset();

      // Drain the list completely, then request with a same-cycle reclaim.
      for (int i = 0; i < 32; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         chk("drain_preg", s_preg, 32 + i);
         chk("drain_count", s_count, 31 - i);
      end
      chk("drain_empty", int'(empty), 1);
      step(1, 1, 7, 0, 0, 0, 0);
      chk("nobypass_valid", int'(s_valid), 0);
      chk("nobypass_count", s_count, 1);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("bypass_next_valid", int'(s_valid), 1);
      chk("bypass_next_preg", s_preg, 7);
      chk("bypass_next_count", s_count, 0);

      // Mixed traffic long enough to carry both pointers across the wrap.
      do_reset();
      for (int i = 0; i < 200; i++) begin
         step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
              $urandom_range(0, 63), 0, 0, 0, 0);
      end

      // Fill to capacity, then one reclaim too many.
      for (int k = 0; k < 100 && m_count() != P; k++) begin
         step(0, 1, $urandom_range(0, 63), 0, 0, 0, 0);
      end
      chk("full_count", int'(free_count), P);
      chk("full_ovf_clear", int'(overflow_err), 0);
      step(0, 1, 5, 0, 0, 0, 0);
      chk("ovf_set", int'(overflow_err), 1);
      chk("ovf_count", s_count, P);
      for (int i = 0; i < 5; i++) step(1, 1, i, 0, 0, 0, 0);
      chk("ovf_sticky", int'(overflow_err), 1);
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
